// File: rtl/apb_pkg.sv
// Shared APB master types: FSM states, default bus widths
// and the response bundle used by APB requesters.
package apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } apb_state_e;

    // rdata is carried at the default bus width
    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  err;
        logic                  timeout;
    } apb_rsp_t;

endpackage

// File: rtl/apb_master_bridge_if.sv
// Command/response port plus APB bus of the master bridge.
// master: bridge view; slave: requester + APB peripheral view.
interface apb_master_bridge_if #(
    parameter int ADDR_W = apb_pkg::APB_ADDR_W,
    parameter int DATA_W = apb_pkg::APB_DATA_W
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;
    logic [ADDR_W-1:0] PADDR;
    logic              PSELx;
    logic              PENABLE;
    logic              PWRITE;
    logic [DATA_W-1:0] PWDATA;
    logic              PREADY;
    logic [DATA_W-1:0] PRDATA;
    logic              PSLVERR;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        input  PREADY, PRDATA, PSLVERR,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output PADDR, PSELx, PENABLE, PWRITE, PWDATA
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        output PREADY, PRDATA, PSLVERR,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  PADDR, PSELx, PENABLE, PWRITE, PWDATA
    );

endinterface

// File: rtl/apb_wait_timer.sv
// Saturating ACCESS wait-state counter with expiry flag.
// Ports: i_clk, i_rst, i_clr (restart), i_en (count), o_expire.
module apb_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);
    localparam int CW = $clog2(TIMEOUT + 1) + 1;

    logic [CW-1:0] r_cnt;
    logic [CW:0]   w_cnt_inc;

    assign w_cnt_inc = {1'b0, r_cnt} + (CW+1)'(1);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !(&r_cnt)) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Fires on the wait cycle whose increment reaches TIMEOUT
    assign o_expire = (TIMEOUT != 0) && i_en
                   && (w_cnt_inc >= (CW+1)'(TIMEOUT));

endmodule

// File: rtl/apb_master_bridge.sv
// Single-transfer APB requester: command in, SETUP/ACCESS out, one-cycle response.
// Ports: PCLK, PRESET (async, high), bus (apb_master_bridge_if.master).
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 16
) (
    input logic PCLK,
    input logic PRESET,
    apb_master_bridge_if.master bus
);
    apb_state_e        r_state, w_state_nx;
    logic              r_psel, w_psel_nx;
    logic              r_pen, w_pen_nx;
    logic              r_pwrite;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;
    logic              r_rsp_valid, w_rsp_valid_nx;
    apb_rsp_t          r_rsp, w_rsp_nx;
    logic              w_start;
    logic              w_wait;
    logic              w_expired;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .i_clk    (PCLK),
        .i_rst    (PRESET),
        .i_clr    (w_start),
        .i_en     (w_wait),
        .o_expire (w_expired)
    );

    always_comb begin
        w_state_nx     = r_state;
        w_psel_nx      = r_psel;
        w_pen_nx       = r_pen;
        w_rsp_valid_nx = 1'b0;
        w_rsp_nx       = '0;
        w_start        = 1'b0;
        w_wait         = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.req_valid) begin
                    w_start    = 1'b1;
                    w_psel_nx  = 1'b1;
                    w_state_nx = SETUP;
                end
            end
            SETUP: begin
                w_pen_nx   = 1'b1;
                w_state_nx = ACCESS;
            end
            ACCESS: begin
                if (bus.PREADY) begin
                    w_psel_nx      = 1'b0;
                    w_pen_nx       = 1'b0;
                    w_rsp_valid_nx = 1'b1;
                    w_rsp_nx.err   = bus.PSLVERR;
                    // Read data only for clean reads
                    if (!r_pwrite && !bus.PSLVERR) begin
                        w_rsp_nx.rdata = APB_DATA_W'(bus.PRDATA);
                    end
                    w_state_nx = RESP;
                end else begin
                    w_wait = 1'b1;
                    if (w_expired) begin
                        w_psel_nx        = 1'b0;
                        w_pen_nx         = 1'b0;
                        w_rsp_valid_nx   = 1'b1;
                        w_rsp_nx.err     = 1'b1;
                        w_rsp_nx.timeout = 1'b1;
                        w_state_nx       = RESP;
                    end
                end
            end
            RESP: begin
                w_state_nx = IDLE;
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_psel      <= 1'b0;
            r_pen       <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp       <= '0;
        end else begin
            r_psel      <= w_psel_nx;
            r_pen       <= w_pen_nx;
            r_rsp_valid <= w_rsp_valid_nx;
            r_rsp       <= w_rsp_nx;
            // Address phase held until the next accepted command
            if (w_start) begin
                r_pwrite <= bus.req_write;
                r_paddr  <= bus.req_addr;
                r_pwdata <= bus.req_wdata;
            end
        end
    end

    assign bus.req_ready   = (r_state == IDLE);
    assign bus.PSELx       = r_psel;
    assign bus.PENABLE     = r_pen;
    assign bus.PWRITE      = r_pwrite;
    assign bus.PADDR       = r_paddr;
    assign bus.PWDATA      = r_pwdata;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_rdata   = DATA_W'(r_rsp.rdata);
    assign bus.rsp_err     = r_rsp.err;
    assign bus.rsp_timeout = r_rsp.timeout;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge (TIMEOUT=4) with a
// small memory-backed APB slave model.
module tb_apb_master_bridge;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    apb_master_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    apb_master_bridge #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (4)
    ) dut (
        .PCLK   (clk),
        .PRESET (rst),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    // Slave model
    int          cfg_waits = 0;
    logic        cfg_err   = 1'b0;
    logic        cfg_hang  = 1'b0;
    int          wcnt;
    logic [31:0] mem [16];

    always @(posedge clk or posedge rst) begin
        if (rst) wcnt <= 0;
        else if (bus.PSELx && bus.PENABLE && !bus.PREADY) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
            mem[3] <= 32'h3333_3333;
            mem[5] <= 32'hDEAD_BEEF;
            mem[9] <= 32'hFFFF_0000;
        end else if (bus.PSELx && bus.PENABLE && bus.PREADY
                     && bus.PWRITE && !cfg_err) begin
            mem[bus.PADDR[3:0]] <= bus.PWDATA;
        end
    end

    assign bus.PREADY  = bus.PSELx && bus.PENABLE && !cfg_hang
                      && (wcnt >= cfg_waits);
    assign bus.PRDATA  = mem[bus.PADDR[3:0]];
    assign bus.PSLVERR = cfg_err;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic        err;
        logic        hang;
        logic [31:0] e_rdata;
        logic        e_err;
        logic        e_to;
        int          e_lat;
    } vec_t;

    vec_t vt [10];

    task automatic xfer(input int idx);
        vec_t v;
        int   k;
        int   n;
        logic got;
        v = vt[idx];
        cfg_waits     = v.waits;
        cfg_err       = v.err;
        cfg_hang      = v.hang;
        bus.req_valid = 1'b1;
        bus.req_write = v.wr;
        bus.req_addr  = v.addr;
        bus.req_wdata = v.wdata;
        k = 0;
        while (!bus.req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk($sformatf("v%0d req_ready", idx), 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        n   = 1;
        got = 1'b0;
        while (!got && n <= 20) begin
            if (n == 1)
                chk($sformatf("v%0d setup sel/en", idx),
                    {30'd0, bus.PSELx, bus.PENABLE}, 32'b10);
            if (n == 2 || n == v.e_lat - 1)
                chk($sformatf("v%0d access sel/en c%0d", idx, n),
                    {30'd0, bus.PSELx, bus.PENABLE}, 32'b11);
            if (bus.PSELx) begin
                chk($sformatf("v%0d paddr c%0d", idx, n), bus.PADDR, v.addr);
                chk($sformatf("v%0d pwrite c%0d", idx, n),
                    32'(bus.PWRITE), 32'(v.wr));
                if (v.wr)
                    chk($sformatf("v%0d pwdata c%0d", idx, n),
                        bus.PWDATA, v.wdata);
            end
            if (bus.rsp_valid) begin
                got = 1'b1;
            end else begin
                @(negedge clk);
                n++;
            end
        end
        chk($sformatf("v%0d latency", idx), 32'(n), 32'(v.e_lat));
        chk($sformatf("v%0d rdata", idx), bus.rsp_rdata, v.e_rdata);
        chk($sformatf("v%0d err", idx), 32'(bus.rsp_err), 32'(v.e_err));
        chk($sformatf("v%0d timeout", idx),
            32'(bus.rsp_timeout), 32'(v.e_to));
        chk($sformatf("v%0d sel at rsp", idx), 32'(bus.PSELx), 32'd0);
        @(negedge clk);
        chk($sformatf("v%0d rsp cleared", idx),
            {bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, 29'd0} | bus.rsp_rdata,
            32'd0);
        chk($sformatf("v%0d ready after", idx), 32'(bus.req_ready), 32'd1);
        chk($sformatf("v%0d paddr held", idx), bus.PADDR, v.addr);
        cfg_hang  = 1'b0;
        cfg_err   = 1'b0;
        cfg_waits = 0;
    endtask

    logic [31:0] b2b_addr [3];
    logic [31:0] b2b_exp  [3];

    initial begin
        int acc;
        int rcv;
        int seen;
        logic acc_now;

        vt[0] = '{1'b0, 32'd5,  32'h0,         0, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 3};
        vt[1] = '{1'b1, 32'd9,  32'h1234_5678, 2, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 5};
        vt[2] = '{1'b0, 32'd9,  32'h0,         0, 1'b0, 1'b0, 32'h1234_5678, 1'b0, 1'b0, 3};
        vt[3] = '{1'b0, 32'd5,  32'h0,         1, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 4};
        vt[4] = '{1'b0, 32'd5,  32'h0,         0, 1'b0, 1'b1, 32'h0,         1'b1, 1'b1, 6};
        vt[5] = '{1'b0, 32'd5,  32'h0,         3, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 6};
        vt[6] = '{1'b1, 32'd3,  32'hA5A5_0F0F, 0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 3};
        vt[7] = '{1'b0, 32'd3,  32'h0,         0, 1'b0, 1'b0, 32'h3333_3333, 1'b0, 1'b0, 3};
        vt[8] = '{1'b1, 32'd12, 32'hCAFE_F00D, 1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 4};
        vt[9] = '{1'b0, 32'd12, 32'h0,         0, 1'b0, 1'b0, 32'hCAFE_F00D, 1'b0, 1'b0, 3};

        b2b_addr[0] = 32'd5; b2b_exp[0] = 32'hDEAD_BEEF;
        b2b_addr[1] = 32'd9; b2b_exp[1] = 32'hFFFF_0000;
        b2b_addr[2] = 32'd3; b2b_exp[2] = 32'h3333_3333;

        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;

        // Reset state
        @(negedge clk);
        chk("rst sel/en/wr", {29'd0, bus.PSELx, bus.PENABLE, bus.PWRITE}, 32'd0);
        chk("rst paddr", bus.PADDR, 32'd0);
        chk("rst pwdata", bus.PWDATA, 32'd0);
        chk("rst rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, 29'd0}
            | bus.rsp_rdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle req_ready", 32'(bus.req_ready), 32'd1);

        for (int i = 0; i < 10; i++) xfer(i);

        // Reset in the middle of an ACCESS wait state
        cfg_hang      = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 32'd7;
        bus.req_wdata = 32'h7777_0001;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid sel/en before rst", {30'd0, bus.PSELx, bus.PENABLE}, 32'b11);
        #2 rst = 1'b1;
        #1;
        chk("mid rst sel/en/wr", {29'd0, bus.PSELx, bus.PENABLE, bus.PWRITE}, 32'd0);
        chk("mid rst paddr", bus.PADDR, 32'd0);
        chk("mid rst pwdata", bus.PWDATA, 32'd0);
        chk("mid rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        cfg_hang = 1'b0;
        seen     = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.rsp_valid) seen++;
        end
        chk("mid rst no rsp", 32'(seen), 32'd0);
        chk("mid rst ready", 32'(bus.req_ready), 32'd1);

        // Back-to-back with req_valid held high
        acc = 0;
        rcv = 0;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = b2b_addr[0];
        for (int c = 0; c < 13; c++) begin
            chk($sformatf("b2b ready c%0d", c), 32'(bus.req_ready),
                32'((c % 4) == 0));
            chk($sformatf("b2b rsp_valid c%0d", c), 32'(bus.rsp_valid),
                32'((c % 4) == 3));
            if (bus.rsp_valid && rcv < 3) begin
                chk($sformatf("b2b rdata %0d", rcv), bus.rsp_rdata, b2b_exp[rcv]);
                rcv++;
            end
            acc_now = bus.req_valid && bus.req_ready;
            @(negedge clk);
            if (acc_now) begin
                acc++;
                if (acc < 3) bus.req_addr = b2b_addr[acc];
                else bus.req_valid = 1'b0;
            end
        end
        chk("b2b accepted", 32'(acc), 32'd3);
        chk("b2b responses", 32'(rcv), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
Upstream APB requester for the peripheral slaves (GPIO and peers) on the APB bus. It accepts single read/write requests from a simple valid/ready command port. It then drives a compliant APB SETUP→ACCESS sequence, honouring PREADY wait states. It returns read data plus error and timeout status on a one-cycle response strobe.

Parameters:
ADDR_W, 32, width of req_addr/PADDR
DATA_W, 32, width of all data buses
TIMEOUT, 16, maximum ACCESS cycles waiting for PREADY; 0 disables the timeout

Ports:
PCLK  in  1  clock, all logic on rising edge
PRESET  in  1  asynchronous, active-high reset
req_valid  in  1  command request
req_ready  out  1  bridge can accept a command
req_write  in  1  1=write, 0=read
req_addr  in  ADDR_W  target address
req_wdata  in  DATA_W  write data
rsp_valid  out  1  one-cycle completion strobe
rsp_rdata  out  DATA_W  read data; 0 for writes, errors and timeouts
rsp_err  out  1  PSLVERR seen, or timeout
rsp_timeout  out  1  transfer aborted by timeout
PADDR  out  ADDR_W  APB address
PSELx  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PWDATA  out  DATA_W  APB write data
PREADY  in  1  slave ready
PRDATA  in  DATA_W  slave read data
PSLVERR  in  1  slave error

Behaviour:
- Reset (async, PRESET=1): state=IDLE. All outputs 0: PSELx, PENABLE, PWRITE, PADDR, PWDATA, rsp_*, and the timeout counter. A reset mid-transfer aborts it immediately; no rsp_valid is produced for it.
- All APB and rsp outputs are registered. req_ready is combinational: 1 iff state==IDLE.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: when req_valid&&req_ready at edge N, latch addr/wdata/write into PADDR/PWDATA/PWRITE. Go to SETUP. Cycle N+1 shows PSELx=1, PENABLE=0.
- SETUP: unconditionally go to ACCESS. PSELx=1, PENABLE=1 in the next cycle.
- ACCESS: sample PREADY each edge.
  - PREADY=1: capture PRDATA (reads only, else 0) and PSLVERR. Drop PSELx/PENABLE. Go to RESP.
  - PREADY=0: increment wait counter.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT: drop PSELx/PENABLE. Go to RESP with timeout flag set, rsp_rdata=0, rsp_err=1.
- RESP: rsp_valid=1 for exactly one cycle with the captured data and flags. Next state is IDLE. rsp_* return to 0 the following cycle.
- Zero-wait latency: accept at edge N, rsp_valid in cycle N+3. Each wait state adds 1 cycle. Maximum throughput is 1 transfer per 4 cycles.
- PADDR, PWRITE and PWDATA are held stable from SETUP through the end of ACCESS. They retain their last value in IDLE; they are not cleared.
- PSLVERR is only sampled when PREADY=1 in ACCESS. It is ignored elsewhere.
- On PSLVERR=1 with a read, rsp_rdata is forced to 0.
- The wait counter is TIMEOUT-width+1 bits, saturating. It clears on entry to SETUP.
- A req_valid arriving while busy is ignored (req_ready=0). The requester must hold it until accepted.
- TIMEOUT=0: ACCESS waits indefinitely; rsp_timeout is never asserted.

Decomposition:
- Package apb_pkg holds:
  - the state enum (IDLE, SETUP, ACCESS, RESP);
  - the default ADDR_W/DATA_W constants;
  - a response struct {rdata, err, timeout} shared with future APB masters.
- One sub-module is natural: apb_wait_timer, covering counter, clear, enable, and an expired flag at TIMEOUT.

Test Plan:
- Zero-wait read: slave holds 0xDEADBEEF at addr 5, PREADY tied 1. Request read addr 5 at cycle 0 → PSELx=1 cycle 1, PENABLE=1 cycle 2, rsp_valid=1 cycle 3 with rsp_rdata=0xDEADBEEF, rsp_err=0.
- Write with 2 wait states: write 0x12345678 to addr 9, PREADY low 2 ACCESS cycles → PADDR/PWDATA stable throughout, rsp_valid in cycle 5, rsp_rdata=0; slave readback returns 0x12345678.
- Slave error: PSLVERR=1 with PREADY=1 on a read → rsp_err=1, rsp_timeout=0, rsp_rdata=0.
- Timeout (TIMEOUT=4): PREADY held 0 → PSELx drops after 4 ACCESS cycles, rsp_valid with rsp_err=1, rsp_timeout=1; next request proceeds normally.
- Reset mid-ACCESS: assert PRESET in the middle of a wait state → all outputs 0 asynchronously, no rsp_valid, req_ready=1 after release.
- Back-to-back: req_valid held high for 3 commands → req_ready=1 only in IDLE, each command accepted once, responses returned in order every 4 cycles.
